// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding and the MUL
// instruction decode constants used by the execute stage.
package iter_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // MUL is SPECIAL2 opcode with funct 000010
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [5:0] FUNCT_MUL    = 6'b000010;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: fixed WIDTH-cycle latency, sign handled by
// multiplying magnitudes and negating the final accumulator.
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mult_begin,
  input  logic                 mult_signed,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end,
  output logic                 mult_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  mul_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [2*WIDTH-1:0]   acc_step;

  // The most-negative operand maps to 2^(WIDTH-1), which is the right magnitude.
  assign op1_mag  = (mult_signed && mult_op1[WIDTH-1]) ? (~mult_op1 + ONE_W) : mult_op1;
  assign op2_mag  = (mult_signed && mult_op2[WIDTH-1]) ? (~mult_op2 + ONE_W) : mult_op2;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (mult_begin) begin
          state_d  = ST_BUSY;
          mcand_d  = {{WIDTH{1'b0}}, op1_mag};
          mplier_d = op2_mag;
          neg_d    = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        // Dropping mult_begin abandons the multiply and leaves product alone.
        if (!mult_begin) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_DONE;
            product_d = neg_q ? (~acc_step + ONE_2W) : acc_step;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product   = product_q;
  assign mult_end  = (state_q == ST_DONE);
  assign mult_busy = (state_q == ST_BUSY);

endmodule
